// File: rtl/lane_deskew.sv
// lane_deskew: multi-lane deskew buffer aligned on a MARKER word.
// Each lane owns a DEPTH-word ring; once every lane has captured a marker the
// lanes are popped together and emitted as one registered word set.
// Optional statistics (lane_skew, err_count) are built only when the macro
// DESKEW_STATS_EN is defined; otherwise those ports are tied to zero.
module lane_deskew #(
  parameter int unsigned      WIDTH  = 36,
  parameter int unsigned      NLANE  = 4,
  parameter int unsigned      DEPTH  = 8,
  parameter logic [WIDTH-1:0] MARKER = 36'h0_0000_00BC,
  parameter logic [WIDTH-1:0] MMASK  = 36'h0_0000_00FF,
  localparam int unsigned     AW     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      init_n,
  input  logic [NLANE-1:0]          lane_valid,
  input  logic [NLANE*WIDTH-1:0]    lane_data,
  input  logic                      realign,
  output logic                      out_valid,
  output logic [NLANE*WIDTH-1:0]    out_data,
  output logic                      aligned,
  output logic                      skew_err,
  output logic [NLANE*(AW+1)-1:0]   lane_skew,
  output logic [7:0]                err_count
);

  localparam logic [AW:0]   OccFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OccOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic [0:0] {StHunt, StAligned} state_e;

  state_e                 state_q, state_d;
  logic [NLANE-1:0]       seen_q, seen_d;
  logic [AW-1:0]          wr_ptr_q [NLANE];
  logic [AW-1:0]          wr_ptr_d [NLANE];
  logic [AW-1:0]          rd_ptr_q [NLANE];
  logic [AW-1:0]          rd_ptr_d [NLANE];
  logic [AW:0]            occ_q    [NLANE];
  logic [AW:0]            occ_d    [NLANE];
  logic [WIDTH-1:0]       mem_q    [NLANE][DEPTH];

  logic                   out_valid_q, out_valid_d;
  logic [NLANE*WIDTH-1:0] out_data_q, out_data_d;
  logic                   skew_err_q, skew_err_d;

  logic [WIDTH-1:0]       lane_word  [NLANE];
  logic [WIDTH-1:0]       pop_word   [NLANE];
  logic [AW-1:0]          wr_addr    [NLANE];
  logic [NLANE-1:0]       is_marker, accept, ovf_lane, wr_en, pop_marker;
  logic                   rd_en, overflow, mismatch, err, flush;

  // Decode this cycle's writes, the joint read and any error condition.
  always_comb begin
    rd_en = (state_q == StAligned);
    for (int i = 0; i < NLANE; i++) begin
      lane_word[i] = lane_data[i*WIDTH +: WIDTH];
      is_marker[i] = (lane_word[i] & MMASK) == (MARKER & MMASK);
      // A lane is ready if it holds a word or one is arriving now (bypass).
      if (occ_q[i] == '0 && !lane_valid[i]) rd_en = 1'b0;
    end
    for (int i = 0; i < NLANE; i++) begin
      // Unseen lanes discard everything up to their first marker.
      accept[i]     = lane_valid[i] && (seen_q[i] || is_marker[i]);
      ovf_lane[i]   = accept[i] && (occ_q[i] == OccFull) && !rd_en;
      wr_en[i]      = accept[i] && !ovf_lane[i];
      wr_addr[i]    = seen_q[i] ? wr_ptr_q[i] : '0;
      pop_word[i]   = (occ_q[i] == '0) ? lane_word[i] : mem_q[i][rd_ptr_q[i]];
      pop_marker[i] = (pop_word[i] & MMASK) == (MARKER & MMASK);
    end
    overflow = |ovf_lane;
    // Popped set must be all markers or no markers.
    mismatch = rd_en && (pop_marker != '0) && (pop_marker != '1);
    err      = overflow | mismatch;
    flush    = err | realign;
  end

  // Next-state for pointers, occupancies, lock state and registered outputs.
  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_valid_d = rd_en && !flush;
    out_data_d  = out_data_q;
    skew_err_d  = err;
    if (out_valid_d) begin
      for (int i = 0; i < NLANE; i++) out_data_d[i*WIDTH +: WIDTH] = pop_word[i];
    end
    if (flush) begin
      state_d = StHunt;
      seen_d  = '0;
      for (int i = 0; i < NLANE; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        occ_d[i]    = '0;
      end
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_en[i]) wr_ptr_d[i] = wr_addr[i] + PtrOne;
        if (rd_en)    rd_ptr_d[i] = rd_ptr_q[i] + PtrOne;
        case ({wr_en[i], rd_en})
          2'b10:   occ_d[i] = occ_q[i] + OccOne;
          2'b01:   occ_d[i] = occ_q[i] - OccOne;
          default: occ_d[i] = occ_q[i];
        endcase
      end
      seen_d = seen_q | wr_en;
      if (state_q == StHunt && (&seen_d)) state_d = StAligned;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= StHunt;
      seen_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skew_err_q  <= 1'b0;
      for (int i = 0; i < NLANE; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        occ_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      skew_err_q  <= skew_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  // Lane ring storage; contents are meaningless after a flush so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (wr_en[i]) mem_q[i][wr_addr[i]] <= lane_word[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign skew_err  = skew_err_q;
  assign aligned   = (state_q == StAligned);

`ifdef DESKEW_STATS_EN
  logic [NLANE*(AW+1)-1:0] lane_skew_q, lane_skew_d;
  logic [7:0]              err_count_q, err_count_d;

  // Latch per-lane fill at lock; count error pulses with saturation.
  always_comb begin
    lane_skew_d = lane_skew_q;
    err_count_d = err_count_q;
    if (state_q == StHunt && state_d == StAligned) begin
      for (int i = 0; i < NLANE; i++) lane_skew_d[i*(AW+1) +: AW+1] = occ_d[i];
    end
    if (err && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  // Statistics registers, cleared only by init_n.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      lane_skew_q <= '0;
      err_count_q <= '0;
    end else begin
      lane_skew_q <= lane_skew_d;
      err_count_q <= err_count_d;
    end
  end

  assign lane_skew = lane_skew_q;
  assign err_count = err_count_q;
`else
  assign lane_skew = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_lane_deskew.sv
// tb_lane_deskew: randomized and directed stimulus for lane_deskew, checked
// cycle by cycle against a queue-based reference model of the lane buffers.
module tb_lane_deskew;

  localparam int unsigned WIDTH = 36;
  localparam int unsigned NLANE = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned SW    = AW + 1;
  localparam logic [WIDTH-1:0] MARKER = 36'h0_0000_00BC;
  localparam logic [WIDTH-1:0] MMASK  = 36'h0_0000_00FF;

  logic                    clk;
  logic                    init_n;
  logic [NLANE-1:0]        lane_valid;
  logic [NLANE*WIDTH-1:0]  lane_data;
  logic                    realign;
  logic                    out_valid;
  logic [NLANE*WIDTH-1:0]  out_data;
  logic                    aligned;
  logic                    skew_err;
  logic [NLANE*SW-1:0]     lane_skew;
  logic [7:0]              err_count;

  lane_deskew #(
    .WIDTH (WIDTH),
    .NLANE (NLANE),
    .DEPTH (DEPTH),
    .MARKER(MARKER),
    .MMASK (MMASK)
  ) dut (
    .clk       (clk),
    .init_n    (init_n),
    .lane_valid(lane_valid),
    .lane_data (lane_data),
    .realign   (realign),
    .out_valid (out_valid),
    .out_data  (out_data),
    .aligned   (aligned),
    .skew_err  (skew_err),
    .lane_skew (lane_skew),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one FIFO per lane plus a lock flag.
  bit                      m_aligned;
  bit [NLANE-1:0]          m_seen;
  logic [WIDTH-1:0]        mq [NLANE][$];
  bit                      exp_ov;
  bit                      exp_se;
  logic [NLANE*WIDTH-1:0]  exp_od;
  logic [7:0]              exp_ec;
  logic [NLANE*SW-1:0]     exp_ls;

  function automatic bit is_mk(input logic [WIDTH-1:0] w);
    return (w & MMASK) == (MARKER & MMASK);
  endfunction

  task automatic model_reset();
    m_aligned = 0;
    m_seen    = '0;
    for (int i = 0; i < NLANE; i++) mq[i].delete();
    exp_ov = 0;
    exp_se = 0;
    exp_od = '0;
    exp_ec = '0;
    exp_ls = '0;
  endtask

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    bit               rd, ovf, mm, fl;
    bit [NLANE-1:0]   acc, pm;
    logic [WIDTH-1:0] w, pw [NLANE];
    rd  = m_aligned;
    ovf = 0;
    mm  = 0;
    pm  = '0;
    for (int i = 0; i < NLANE; i++)
      if (mq[i].size() == 0 && !lane_valid[i]) rd = 0;
    for (int i = 0; i < NLANE; i++) begin
      w      = lane_data[i*WIDTH +: WIDTH];
      acc[i] = lane_valid[i] && (m_seen[i] || is_mk(w));
      if (acc[i] && mq[i].size() == DEPTH && !rd) ovf = 1;
      pw[i]  = (mq[i].size() > 0) ? mq[i][0] : w;
      pm[i]  = is_mk(pw[i]);
    end
    if (rd && pm != '0 && pm != {NLANE{1'b1}}) mm = 1;
    fl     = ovf || mm || realign;
    exp_se = ovf || mm;
`ifdef DESKEW_STATS_EN
    if (exp_se && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
`endif
    exp_ov = rd && !fl;
    if (exp_ov)
      for (int i = 0; i < NLANE; i++) exp_od[i*WIDTH +: WIDTH] = pw[i];
    if (fl) begin
      for (int i = 0; i < NLANE; i++) mq[i].delete();
      m_seen    = '0;
      m_aligned = 0;
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (acc[i]) mq[i].push_back(lane_data[i*WIDTH +: WIDTH]);
        if (rd) void'(mq[i].pop_front());
      end
      m_seen = m_seen | acc;
      if (!m_aligned && (&m_seen)) begin
        m_aligned = 1;
`ifdef DESKEW_STATS_EN
        for (int i = 0; i < NLANE; i++) exp_ls[i*SW +: SW] = SW'(mq[i].size());
`endif
      end
    end
  endtask

  // Lane sources: garbage before start, then word k = MARKER every 64, else k<<8.
  int cyc;
  int st [NLANE];
  int src_k [NLANE];
  int omit_lane;
  int omit_k;
  int first_valid, first_err, n_valid, n_err;

  task automatic start_src(input int s0, input int s1, input int s2, input int s3);
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    for (int i = 0; i < NLANE; i++) src_k[i] = 0;
    cyc         = 0;
    omit_lane   = -1;
    omit_k      = -1;
    first_valid = -1;
    first_err   = -1;
    n_valid     = 0;
    n_err       = 0;
  endtask

  task automatic drive(input bit [NLANE-1:0] drop, input bit rl);
    logic [WIDTH-1:0] w;
    realign = rl;
    for (int i = 0; i < NLANE; i++) begin
      w = lane_data[i*WIDTH +: WIDTH];
      if (cyc < st[i]) begin
        lane_valid[i] = 1'b1;
        w = WIDTH'({$urandom(), $urandom()});
        w[7:0] = 8'h11;
      end else if (drop[i]) begin
        lane_valid[i] = 1'b0;
      end else begin
        lane_valid[i] = 1'b1;
        if (src_k[i] % 64 == 0 && !(i == omit_lane && src_k[i] == omit_k)) w = MARKER;
        else w = WIDTH'(src_k[i]) << 8;
        src_k[i]++;
      end
      lane_data[i*WIDTH +: WIDTH] = w;
    end
  endtask

  task automatic cycle_once(input bit [NLANE-1:0] drop, input bit rl);
    drive(drop, rl);
    model_step();
    @(posedge clk);
    #1;
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("aligned", aligned, m_aligned);
    check_eq("skew_err", skew_err, exp_se);
    check_eq("out_data", out_data, exp_od);
    check_eq("err_count", err_count, exp_ec);
    check_eq("lane_skew", lane_skew, exp_ls);
    if (out_valid) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (skew_err) begin
      n_err++;
      if (first_err < 0) first_err = cyc;
    end
    cyc++;
  endtask

  // Asynchronous reset taken between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    init_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_aligned", aligned, 1'b0);
    check_eq("rst_skew_err", skew_err, 1'b0);
    check_eq("rst_err_count", err_count, 8'd0);
    check_eq("rst_lane_skew", lane_skew, '0);
    check_eq("rst_out_data", out_data, '0);
    model_reset();
    lane_valid = '0;
    realign    = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    init_n = 1'b1;
  endtask

  int n_low;

  initial begin
    init_n     = 1'b0;
    lane_valid = '0;
    lane_data  = '0;
    realign    = 1'b0;
    n_checks   = 0;
    n_errors   = 0;
    do_reset();

    // Staggered markers: first set out at edge 16, fill {1,3,5,6} at lock.
    start_src(10, 11, 13, 15);
    repeat (40) cycle_once('0, 1'b0);
    check_eq("t2_first_valid", first_valid, 16);
    check_eq("t2_no_err", n_err, 0);
`ifdef DESKEW_STATS_EN
    check_eq("t2_lane_skew", lane_skew, {4'd1, 4'd3, 4'd5, 4'd6});
`endif

    // Reset in the middle of a live stream.
    check_eq("t1_streaming", out_valid, 1'b1);
    do_reset();

    // Lane 0 overflows at 18 while lane 3 is still hunting.
    start_src(10, 12, 14, 19);
    repeat (24) cycle_once('0, 1'b0);
    check_eq("t3_first_err", first_err, 18);
    check_eq("t3_err_pulses", n_err, 1);
    check_eq("t3_no_valid", n_valid, 0);
    check_eq("t3_hunt", aligned, 1'b0);
`ifdef DESKEW_STATS_EN
    check_eq("t3_err_count", err_count, 8'd1);
`endif
    do_reset();

    // Lane 2 misses the marker at word 64; relock on word 128.
    start_src(2, 3, 4, 5);
    omit_lane = 2;
    omit_k    = 64;
    repeat (200) cycle_once('0, 1'b0);
    check_eq("t4_err_pulses", n_err, 1);
    check_eq("t4_relocked", aligned, 1'b1);
    do_reset();

    // realign pulse mid-stream, then relock.
    start_src(0, 1, 2, 3);
    repeat (100) cycle_once('0, 1'b0);
    cycle_once('0, 1'b1);
    check_eq("t5_valid_dropped", out_valid, 1'b0);
    check_eq("t5_unaligned", aligned, 1'b0);
    repeat (150) cycle_once('0, 1'b0);
    check_eq("t5_relocked", aligned, 1'b1);
    check_eq("t5_no_err", n_err, 0);
    do_reset();

    // Lane 1 is the latest lane; the first 2-cycle gap drains its one
    // buffered word, so only the second gap shows the full 2-cycle hole.
    start_src(0, 3, 1, 2);
    n_low = 0;
    for (int c = 0; c < 60; c++) begin
      cycle_once((c == 20 || c == 21 || c == 40 || c == 41) ? 4'b0010 : 4'b0000, 1'b0);
      if (c >= 36 && c <= 50 && !out_valid) n_low++;
    end
    check_eq("t6_low_cycles", n_low, 2);
    check_eq("t6_no_err", n_err, 0);
    do_reset();

    // Random offsets, dropouts and occasional realign.
    for (int r = 0; r < 6; r++) begin
      start_src($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
      for (int c = 0; c < 1500; c++) begin
        bit [NLANE-1:0] d;
        for (int i = 0; i < NLANE; i++) d[i] = ($urandom_range(31) == 0);
        cycle_once(d, $urandom_range(499) == 0);
      end
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
